// File: rtl/sample_frame_source_pkg.sv
// Shared definitions for the USB uplink sample source: command words shared
// with the USB FIFO controller, frame geometry and the handoff state type.
package sample_frame_source_pkg;

   localparam int IDX_W     = 7;
   localparam int FRAME_LEN = 2 ** IDX_W;
   localparam int SAMPLE_W  = 16;
   localparam int PAIR_W    = 2 * SAMPLE_W;

   // First and last frame index. The controller sweeps from last down to first.
   localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_LEN - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

   // Command words latched by the USB controller
   localparam logic [15:0] COMMAND_NOOP  = 16'd0;
   localparam logic [15:0] COMMAND_START = 16'd1;
   localparam logic [15:0] COMMAND_STOP  = 16'd2;

   typedef enum logic [2:0] {
      H_IDLE      = 3'd0,
      H_WAIT_TOP  = 3'd1,
      H_COPY      = 3'd2,
      H_GAP       = 3'd3,
      H_RETRY_GAP = 3'd4
   } handoff_state_t;

   // Bank word layout: y in the upper half, x in the lower half
   function automatic logic [PAIR_W-1:0] pack_pair(input logic [SAMPLE_W-1:0] y,
                                                    input logic [SAMPLE_W-1:0] x);
      return {y, x};
   endfunction

endpackage

// File: rtl/sample_frame_source_bank.sv
// Ping-pong pair of 128 x 32 frame banks. One bank is written by capture,
// the other is served to the USB controller through two async read ports
// (y and x halves, independent indices). A swap exchanges their roles.
module frame_bank_pair
   import sample_frame_source_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                swap,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_addr,
   input  logic [PAIR_W-1:0]   wr_data,
   input  logic [IDX_W-1:0]    rd_index_y,
   input  logic [IDX_W-1:0]    rd_index_x,
   output logic [SAMPLE_W-1:0] rd_data_y,
   output logic [SAMPLE_W-1:0] rd_data_x
);

   logic [PAIR_W-1:0] bank0_r [FRAME_LEN];
   logic [PAIR_W-1:0] bank1_r [FRAME_LEN];

   // 0: bank0 captures and bank1 serves; 1: the reverse
   logic capture_sel_r;

   // Track which bank is the capture bank; a swap flips roles
   always_ff @(posedge clk) begin
      if (reset) begin
         capture_sel_r <= 1'b0;
      end else if (swap) begin
         capture_sel_r <= ~capture_sel_r;
      end else begin
         capture_sel_r <= capture_sel_r;
      end
   end

   // Write the incoming pair into the capture bank only; contents survive reset.
   // The swap takes effect after this edge, so the final pair of a frame
   // lands in the bank that is about to become the serve bank.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         if (capture_sel_r) begin
            bank1_r[wr_addr] <= wr_data;
         end else begin
            bank0_r[wr_addr] <= wr_data;
         end
      end
   end

   // Zero-latency lookup into the serve bank for the controller
   always_comb begin
      if (capture_sel_r) begin
         rd_data_y = bank0_r[rd_index_y][PAIR_W-1:SAMPLE_W];
         rd_data_x = bank0_r[rd_index_x][SAMPLE_W-1:0];
      end else begin
         rd_data_y = bank1_r[rd_index_y][PAIR_W-1:SAMPLE_W];
         rd_data_x = bank1_r[rd_index_x][SAMPLE_W-1:0];
      end
   end

endmodule

// File: rtl/sample_frame_source.sv
// Producer side of the USB uplink sample interface. Captures (y, x) pairs
// into ping-pong frame banks, signals a ready frame with start_sending,
// detects the controller's 127..0 read sweep as copy completion and obeys
// START/STOP command words.
module sample_frame_source
   import sample_frame_source_pkg::*;
#(
   parameter int HANDOFF_TIMEOUT = 1024,
   parameter int GAP_CYCLES      = 4
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample_yaxis,
   input  logic [SAMPLE_W-1:0] sample_xaxis,
   input  logic [15:0]         command,
   input  logic [IDX_W-1:0]    read_index_yaxis,
   input  logic [IDX_W-1:0]    read_index_xaxis,
   output logic [SAMPLE_W-1:0] data_yaxis,
   output logic [SAMPLE_W-1:0] data_xaxis,
   output logic                start_sending,
   output logic                running,
   output logic [15:0]         frames_sent,
   output logic [15:0]         frames_dropped
);

   localparam int TO_W  = $clog2(HANDOFF_TIMEOUT + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(HANDOFF_TIMEOUT - 1);
   localparam logic [TO_W-1:0]  TO_ZERO  = TO_W'(0);
   localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

   logic                cmd_start_s;
   logic                cmd_stop_s;
   logic                wr_en_s;
   logic                frame_done_s;
   logic                serve_clear_s;
   logic                swap_s;
   logic [PAIR_W-1:0]   wr_data_s;

   logic                running_r;
   logic [IDX_W-1:0]    wr_ptr_r;
   logic                serve_full_r;
   handoff_state_t      state_r;
   logic [TO_W-1:0]     timeout_cnt_r;
   logic [GAP_W-1:0]    gap_cnt_r;
   logic                start_sending_r;
   logic [15:0]         frames_sent_r;
   logic [15:0]         frames_dropped_r;

   // Decode the command level and qualify this cycle's capture/handoff events.
   // A STOP cycle never writes. A frame that completes in the same cycle the
   // copy finishes still swaps, because the serve bank is released that cycle.
   always_comb begin
      cmd_start_s   = (command == COMMAND_START);
      cmd_stop_s    = (command == COMMAND_STOP);
      wr_en_s       = running_r && sample_valid && !cmd_stop_s;
      frame_done_s  = wr_en_s && (wr_ptr_r == IDX_LAST);
      serve_clear_s = (state_r == H_COPY) && (read_index_yaxis == IDX_FIRST);
      swap_s        = frame_done_s && (!serve_full_r || serve_clear_s);
      wr_data_s     = pack_pair(sample_yaxis, sample_xaxis);
   end

   // Run state and capture pointer; STOP discards the partial frame
   always_ff @(posedge clk) begin
      if (reset) begin
         running_r <= 1'b0;
         wr_ptr_r  <= IDX_FIRST;
      end else begin
         if (cmd_start_s) begin
            running_r <= 1'b1;
         end else if (cmd_stop_s) begin
            running_r <= 1'b0;
         end else begin
            running_r <= running_r;
         end
         if (cmd_stop_s) begin
            wr_ptr_r <= IDX_FIRST;
         end else if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + IDX_ONE;   // 127 wraps to 0 at frame end
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
      end
   end

   // Serve-bank occupancy plus sent/dropped frame counters
   always_ff @(posedge clk) begin
      if (reset) begin
         serve_full_r     <= 1'b0;
         frames_sent_r    <= 16'd0;
         frames_dropped_r <= 16'd0;
      end else begin
         if (swap_s) begin
            serve_full_r <= 1'b1;
         end else if (serve_clear_s) begin
            serve_full_r <= 1'b0;
         end else begin
            serve_full_r <= serve_full_r;
         end
         if (serve_clear_s) begin
            frames_sent_r <= frames_sent_r + 16'd1;
         end else begin
            frames_sent_r <= frames_sent_r;
         end
         if (frame_done_s && !swap_s && (frames_dropped_r != 16'hFFFF)) begin
            frames_dropped_r <= frames_dropped_r + 16'd1;
         end else begin
            frames_dropped_r <= frames_dropped_r;
         end
      end
   end

   // Handoff sequencer: hold start_sending until the controller sweeps the
   // serve bank from the top, retrying after a short gap if it never starts
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r         <= H_IDLE;
         start_sending_r <= 1'b0;
         timeout_cnt_r   <= TO_ZERO;
         gap_cnt_r       <= GAP_ZERO;
      end else begin
         case (state_r)
            H_IDLE: begin
               if (serve_full_r) begin
                  state_r         <= H_WAIT_TOP;
                  start_sending_r <= 1'b1;
                  timeout_cnt_r   <= TO_ZERO;
               end else begin
                  start_sending_r <= 1'b0;
               end
            end
            H_WAIT_TOP: begin
               if (read_index_yaxis == IDX_LAST) begin
                  state_r <= H_COPY;
               end else if (timeout_cnt_r == TO_LAST) begin
                  state_r         <= H_RETRY_GAP;
                  start_sending_r <= 1'b0;
                  gap_cnt_r       <= GAP_ZERO;
               end else begin
                  timeout_cnt_r <= timeout_cnt_r + TO_ONE;
               end
            end
            H_COPY: begin
               if (serve_clear_s) begin
                  state_r         <= H_GAP;
                  start_sending_r <= 1'b0;
                  gap_cnt_r       <= GAP_ZERO;
               end else begin
                  start_sending_r <= 1'b1;
               end
            end
            H_GAP: begin
               if (gap_cnt_r == GAP_LAST) begin
                  state_r <= H_IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r + GAP_ONE;
               end
            end
            H_RETRY_GAP: begin
               if (gap_cnt_r == GAP_LAST) begin
                  state_r         <= H_WAIT_TOP;
                  start_sending_r <= 1'b1;
                  timeout_cnt_r   <= TO_ZERO;
               end else begin
                  gap_cnt_r <= gap_cnt_r + GAP_ONE;
               end
            end
            default: begin
               state_r         <= H_IDLE;
               start_sending_r <= 1'b0;
            end
         endcase
      end
   end

   frame_bank_pair u_banks (
      .clk        (clk),
      .reset      (reset),
      .swap       (swap_s),
      .wr_en      (wr_en_s),
      .wr_addr    (wr_ptr_r),
      .wr_data    (wr_data_s),
      .rd_index_y (read_index_yaxis),
      .rd_index_x (read_index_xaxis),
      .rd_data_y  (data_yaxis),
      .rd_data_x  (data_xaxis)
   );

   assign start_sending  = start_sending_r;
   assign running        = running_r;
   assign frames_sent    = frames_sent_r;
   assign frames_dropped = frames_dropped_r;

endmodule

// File: tb/tb_sample_frame_source.sv
// Scoreboard bench for sample_frame_source. A frame-level reference model
// queues each frame that should be handed off; a USB-controller model
// sweeps the serve bank on start_sending and checks every word it reads.
module tb_sample_frame_source;
   import sample_frame_source_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        sample_valid;
   logic [15:0] sample_yaxis;
   logic [15:0] sample_xaxis;
   logic [15:0] command;
   logic [6:0]  read_index_yaxis;
   logic [6:0]  read_index_xaxis;
   logic [15:0] data_yaxis;
   logic [15:0] data_xaxis;
   logic        start_sending;
   logic        running;
   logic [15:0] frames_sent;
   logic [15:0] frames_dropped;

   sample_frame_source dut (
      .clk              (clk),
      .reset            (reset),
      .sample_valid     (sample_valid),
      .sample_yaxis     (sample_yaxis),
      .sample_xaxis     (sample_xaxis),
      .command          (command),
      .read_index_yaxis (read_index_yaxis),
      .read_index_xaxis (read_index_xaxis),
      .data_yaxis       (data_yaxis),
      .data_xaxis       (data_xaxis),
      .start_sending    (start_sending),
      .running          (running),
      .frames_sent      (frames_sent),
      .frames_dropped   (frames_dropped)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // reference model state
   logic        m_running;
   logic        m_busy;
   logic [15:0] m_sent;
   logic [15:0] m_dropped;
   logic [31:0] m_part [$];
   logic [31:0] exp_q [$];

   // controller model configuration (written by stimulus) and status
   int ctl_delay  = 2;
   bit ctl_never  = 1'b0;
   bit ctl_abort  = 1'b0;
   bit sweep_zero = 1'b0;
   bit abort_hit  = 1'b0;
   bit ctl_busy   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: frame-level bookkeeping evaluated at each clock edge
   initial begin : ref_model
      logic clear;
      logic got;
      m_running = 1'b0; m_busy = 1'b0; m_sent = 16'd0; m_dropped = 16'd0;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_running = 1'b0; m_busy = 1'b0; m_sent = 16'd0; m_dropped = 16'd0;
            m_part.delete();
            exp_q.delete();
         end else begin
            clear = sweep_zero;
            got   = 1'b0;
            if (m_running && sample_valid && command != COMMAND_STOP) begin
               m_part.push_back({sample_yaxis, sample_xaxis});
               if (m_part.size() == FRAME_LEN) begin
                  if (!m_busy || clear) begin
                     foreach (m_part[i]) exp_q.push_back(m_part[i]);
                     got = 1'b1;
                  end else if (m_dropped != 16'hFFFF) begin
                     m_dropped = m_dropped + 16'd1;
                  end
                  m_part.delete();
               end
            end
            if (clear) m_sent = m_sent + 16'd1;
            m_busy = got ? 1'b1 : (clear ? 1'b0 : m_busy);
            if (command == COMMAND_START) begin
               m_running = 1'b1;
            end else if (command == COMMAND_STOP) begin
               m_running = 1'b0;
               m_part.delete();
            end
         end
      end
   end

   // USB controller model and monitor: sweep 127..0 after start_sending rises
   initial begin : controller
      logic [31:0] cur [FRAME_LEN];
      bit          have;
      bit          done;
      int          x_off;
      read_index_yaxis = 7'd0;
      read_index_xaxis = 7'd0;
      forever begin
         @(negedge clk);
         sweep_zero = 1'b0;
         if (!ctl_never && start_sending === 1'b1 && reset === 1'b0) begin
            ctl_busy  = 1'b1;
            abort_hit = 1'b0;
            repeat (ctl_delay) @(negedge clk);
            have = (exp_q.size() >= FRAME_LEN);
            chk("frame_queued", 32'(have), 32'd1);
            if (have) begin
               for (int i = 0; i < FRAME_LEN; i++) cur[i] = exp_q.pop_front();
            end
            x_off = int'($urandom_range(0, 127));
            done  = 1'b1;
            for (int k = FRAME_LEN - 1; k >= 0; k--) begin
               if (k != FRAME_LEN - 1) @(negedge clk);
               read_index_yaxis = 7'(k);
               read_index_xaxis = 7'(k + x_off);
               sweep_zero = (k == 0);
               #1;
               if (have) begin
                  chk("data_y", 32'(data_yaxis), 32'(cur[k][31:16]));
                  chk("data_x", 32'(data_xaxis), 32'(cur[read_index_xaxis][15:0]));
               end
               if (ctl_abort && k == 60) begin
                  abort_hit = 1'b1;
                  done = 1'b0;
                  break;
               end
            end
            if (done) begin
               @(negedge clk);
               sweep_zero = 1'b0;
               chk("start_fall", 32'(start_sending), 32'd0);
               read_index_yaxis = 7'd0;
               read_index_xaxis = 7'd0;
            end
            ctl_busy = 1'b0;
         end
      end
   end

   task automatic step(input logic [15:0] cmd, input logic v,
                       input logic [15:0] y, input logic [15:0] x);
      @(negedge clk);
      command = cmd; sample_valid = v; sample_yaxis = y; sample_xaxis = x;
   endtask

   function automatic logic [15:0] noise_cmd();
      logic [15:0] c;
      c = ($urandom_range(0, 1) == 0) ? COMMAND_NOOP : 16'($urandom_range(3, 65535));
      return c;
   endfunction

   // Feed n valid pairs: ramp gives y=i, x=0x100+i; gaps carry noise commands
   task automatic feed(input int n, input bit ramp, input int gap_pct);
      for (int i = 0; i < n; i++) begin
         while (int'($urandom_range(0, 99)) < gap_pct)
            step(noise_cmd(), 1'b0, 16'($urandom), 16'($urandom));
         if (ramp) step(COMMAND_NOOP, 1'b1, 16'(i), 16'(16'h0100 + i));
         else      step(noise_cmd(), 1'b1, 16'($urandom), 16'($urandom));
      end
      step(COMMAND_NOOP, 1'b0, 16'd0, 16'd0);
   endtask

   task automatic check_counters(input string tag);
      chk({tag, "_sent"},    32'(frames_sent),    32'(m_sent));
      chk({tag, "_dropped"}, 32'(frames_dropped), 32'(m_dropped));
      chk({tag, "_running"}, 32'(running),        32'(m_running));
   endtask

   task automatic wait_idle(input int budget);
      int c;
      for (c = 0; c < budget; c++) begin
         step(COMMAND_NOOP, 1'b0, 16'd0, 16'd0);
         if (!m_busy && !ctl_busy && start_sending === 1'b0) break;
      end
      chk("idle_reached", 32'(m_busy || ctl_busy), 32'd0);
      repeat (8) step(COMMAND_NOOP, 1'b0, 16'd0, 16'd0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1; command = COMMAND_NOOP; sample_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_ss"},      32'(start_sending),      32'd0);
      chk({tag, "_run"},     32'(running),            32'd0);
      chk({tag, "_sent"},    32'(frames_sent),        32'd0);
      chk({tag, "_drop"},    32'(frames_dropped),     32'd0);
      chk({tag, "_full"},    32'(dut.serve_full_r),   32'd0);
      reset = 1'b0;
   endtask

   initial begin : stimulus
      int cnt;
      int hi;
      int lo;
      reset = 1'b1; sample_valid = 1'b0; sample_yaxis = 16'd0; sample_xaxis = 16'd0;
      command = COMMAND_NOOP;
      repeat (3) @(negedge clk);
      do_reset("rst");

      // basic frame with ramp data
      ctl_delay = 2;
      step(COMMAND_START, 1'b0, 16'd0, 16'd0);
      feed(128, 1'b1, 0);
      wait_idle(2000);
      check_counters("basic");
      chk("basic_sent_one", 32'(frames_sent), 32'd1);

      // back-to-back continuous stream, prompt controller
      feed(384, 1'b0, 0);
      wait_idle(3000);
      check_counters("b2b");

      // slow consumer
      ctl_delay = 100;
      feed(384, 1'b0, 0);
      wait_idle(4000);
      check_counters("slow");
      ctl_delay = 2;

      // random gaps, noise commands, stop/restart with a valid pair on STOP
      for (int r = 0; r < 3; r++) begin
         feed(int'($urandom_range(20, 200)), 1'b0, 25);
         step(COMMAND_STOP, 1'b1, 16'($urandom), 16'($urandom));
         step(COMMAND_START, 1'b1, 16'($urandom), 16'($urandom));
      end
      feed(256, 1'b0, 20);
      wait_idle(4000);
      check_counters("rand");

      // stop after 50 samples, restart with a full frame
      feed(50, 1'b1, 0);
      step(COMMAND_STOP, 1'b0, 16'd0, 16'd0);
      step(COMMAND_START, 1'b0, 16'd0, 16'd0);
      feed(128, 1'b0, 0);
      wait_idle(2000);
      check_counters("restart");

      // lost handoff: controller never sweeps
      do_reset("rst2");
      ctl_never = 1'b1;
      step(COMMAND_START, 1'b0, 16'd0, 16'd0);
      feed(128, 1'b1, 0);
      for (int r = 0; r < 2; r++) begin
         cnt = 0;
         while (start_sending !== 1'b1 && cnt < 2000) begin @(negedge clk); cnt++; end
         chk("handoff_rise", 32'(start_sending), 32'd1);
         hi = 0;
         while (start_sending === 1'b1 && hi < 1100) begin @(negedge clk); hi++; end
         chk("handoff_high", 32'(hi), 32'd1024);
         lo = 0;
         while (start_sending === 1'b0 && lo < 20) begin @(negedge clk); lo++; end
         chk("retry_gap", 32'(lo), 32'd4);
      end
      chk("lost_sent", 32'(frames_sent), 32'd0);
      do_reset("rst3");
      ctl_never = 1'b0;

      // reset in the middle of a copy at index 60
      ctl_abort = 1'b1;
      step(COMMAND_START, 1'b0, 16'd0, 16'd0);
      feed(128, 1'b0, 0);
      cnt = 0;
      while (!abort_hit && cnt < 600) begin @(negedge clk); #2; cnt++; end
      chk("abort_reached", 32'(abort_hit), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_ss",   32'(start_sending),    32'd0);
      chk("mid_rst_full", 32'(dut.serve_full_r), 32'd0);
      chk("mid_rst_sent", 32'(frames_sent),      32'd0);
      chk("mid_rst_drop", 32'(frames_dropped),   32'd0);
      reset = 1'b0;
      ctl_abort = 1'b0;
      feed(200, 1'b0, 0);
      chk("no_handoff", 32'(start_sending), 32'd0);
      check_counters("post_rst");
      step(COMMAND_START, 1'b0, 16'd0, 16'd0);
      feed(128, 1'b1, 0);
      wait_idle(2000);
      check_counters("after_rst");
      chk("after_rst_sent_one", 32'(frames_sent), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
